// File: rtl/aleste_vshift_pkg.sv
// rtl/aleste_vshift_pkg.sv - shared video types, byte timing constants and helpers
// Exports: scr_mode_t (screen mode), vs_state_t (serializer state),
//          BYTE_CYC_LO/BYTE_CYC_HI (xtal cycles per video byte),
//          ppb_of (pixels per byte), hold_of (cycles per pixel).
package aleste_video_pkg;

    typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} scr_mode_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DRAIN} vs_state_t;

    localparam int BYTE_CYC_LO = 8;
    localparam int BYTE_CYC_HI = 4;

    function automatic logic [3:0] ppb_of(scr_mode_t m);
        case (m)
            MODE2:   return 4'd8;
            MODE1:   return 4'd4;
            default: return 4'd2;
        endcase
    endfunction

    // Cycles each pixel is held: byte length divided evenly across its pixels.
    function automatic logic [2:0] hold_of(scr_mode_t m, logic high);
        logic [3:0] cyc;
        cyc = high ? 4'(BYTE_CYC_HI) : 4'(BYTE_CYC_LO);
        return 3'(cyc / ppb_of(m));
    endfunction

endpackage

// File: rtl/aleste_vshift_if.sv
// rtl/aleste_vshift_if.sv - timing-generator to video-serializer signal bundle
// master: timing generator / CRTC side, drives strobes, mode and DRAM data.
// slave:  serializer side, drives pen/border/pix_stb/underrun.
interface aleste_vshift_if;
    logic       high;
    logic [1:0] mode;
    logic       hsync;
    logic       disp_en;
    logic       mvi_n;
    logic       dis;
    logic [7:0] vdata;
    logic [3:0] pen;
    logic       border;
    logic       pix_stb;
    logic       underrun;

    modport master (
        output high, mode, hsync, disp_en, mvi_n, dis, vdata,
        input  pen, border, pix_stb, underrun
    );

    modport slave (
        input  high, mode, hsync, disp_en, mvi_n, dis, vdata,
        output pen, border, pix_stb, underrun
    );
endinterface

// File: rtl/aleste_vshift_pen_decode.sv
// rtl/aleste_vshift_pen_decode.sv - combinational video byte to pen index decoder
// Ports: byte_in (captured video byte), mode (effective screen mode),
//        idx (pixel index within the byte), pen (4-bit pen index).
module aleste_pen_decode
    import aleste_video_pkg::*;
(
    input  logic [7:0] byte_in,
    input  scr_mode_t  mode,
    input  logic [2:0] idx,
    output logic [3:0] pen
);

    logic [2:0] i2;
    logic [2:0] i1;

    // Only the low index bits are meaningful in the 4- and 2-pixel modes.
    assign i2 = {1'b0, idx[1:0]};
    assign i1 = {2'b00, idx[0]};

    always_comb begin
        pen = 4'd0;
        case (mode)
            MODE2: pen = {3'b000, byte_in[3'd7 - idx]};
            MODE1: pen = {2'b00, byte_in[3'd3 - i2], byte_in[3'd7 - i2]};
            MODE0: pen = {byte_in[3'd1 - i1], byte_in[3'd5 - i1],
                          byte_in[3'd3 - i1], byte_in[3'd7 - i1]};
            MODE3: pen = {2'b00, byte_in[3'd3 - i1], byte_in[3'd7 - i1]};
            default: pen = 4'd0;
        endcase
    end

endmodule

// File: rtl/aleste_vshift.sv
// rtl/aleste_vshift.sv - video byte serializer emitting one pen index per pixel
// Ports: xtal (pixel clock), rst_n (async active-low reset),
//        vif (slave): high, mode, hsync, disp_en, mvi_n, dis, vdata in;
//                     pen, border, pix_stb, underrun out (all registered).
module aleste_vshift
    import aleste_video_pkg::*;
#(
    parameter logic [1:0] RESET_MODE = 2'd1
) (
    input  logic           xtal,
    input  logic           rst_n,
    aleste_vshift_if.slave vif
);

    vs_state_t  state, state_nx;
    logic       hsync_q, mvi_q;
    scr_mode_t  cur_mode, byte_mode;
    logic [7:0] byte_r;
    logic       vis_r;
    logic [2:0] idx, ppb_last;
    logic [1:0] hold_cnt, hold_last;

    logic       load, hs_rise, last_hold, last_pix;
    scr_mode_t  mode_at_load, em_at_load;
    logic [3:0] dec_pen;

    logic [3:0] pen_q, pen_nx;
    logic       border_q, border_nx;
    logic       stb_q, stb_nx;
    logic       underrun_q, underrun_nx;

    always_comb begin
        load         = !vif.mvi_n && mvi_q;
        hs_rise      = vif.hsync && !hsync_q;
        // An hsync edge coinciding with a load already governs that byte.
        mode_at_load = hs_rise ? scr_mode_t'(vif.mode) : cur_mode;
        em_at_load   = (vif.high && mode_at_load == MODE2) ? MODE1 : mode_at_load;
        last_hold    = (hold_cnt == hold_last);
        last_pix     = (idx == ppb_last);
    end

    aleste_pen_decode u_dec (
        .byte_in (byte_r),
        .mode    (byte_mode),
        .idx     (idx),
        .pen     (dec_pen)
    );

    always_ff @(posedge xtal or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs are computed from the counters before this edge's load, so a
    // load shows its first pixel one cycle later.
    always_comb begin
        state_nx    = state;
        pen_nx      = 4'd0;
        border_nx   = 1'b1;
        stb_nx      = 1'b0;
        underrun_nx = underrun_q;
        case (state)
            ST_SHIFT: begin
                pen_nx    = vis_r ? dec_pen : 4'd0;
                border_nx = ~vis_r;
                stb_nx    = (hold_cnt == 2'd0);
                if (last_hold && last_pix) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: underrun_nx = 1'b1;
            default: ;
        endcase
        // A load on the exhausting edge keeps the stream going with no gap.
        if (load) begin
            state_nx = ST_SHIFT;
        end
    end

    always_ff @(posedge xtal or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q    <= 1'b1;
            mvi_q      <= 1'b1;
            cur_mode   <= scr_mode_t'(RESET_MODE);
            byte_mode  <= MODE0;
            byte_r     <= 8'd0;
            vis_r      <= 1'b0;
            idx        <= 3'd0;
            ppb_last   <= 3'd0;
            hold_cnt   <= 2'd0;
            hold_last  <= 2'd0;
            pen_q      <= 4'd0;
            border_q   <= 1'b1;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            hsync_q    <= vif.hsync;
            mvi_q      <= vif.mvi_n;
            pen_q      <= pen_nx;
            border_q   <= border_nx;
            stb_q      <= stb_nx;
            underrun_q <= underrun_nx;
            if (hs_rise) begin
                cur_mode <= scr_mode_t'(vif.mode);
            end
            if (load) begin
                byte_r    <= vif.vdata;
                vis_r     <= vif.dis & vif.disp_en;
                byte_mode <= em_at_load;
                ppb_last  <= 3'(ppb_of(em_at_load) - 4'd1);
                hold_last <= 2'(hold_of(em_at_load, vif.high) - 3'd1);
                idx       <= 3'd0;
                hold_cnt  <= 2'd0;
            end else if (state == ST_SHIFT) begin
                if (last_hold) begin
                    hold_cnt <= 2'd0;
                    if (!last_pix) begin
                        idx <= idx + 3'd1;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 2'd1;
                end
            end
        end
    end

    assign vif.pen      = pen_q;
    assign vif.border   = border_q;
    assign vif.pix_stb  = stb_q;
    assign vif.underrun = underrun_q;

endmodule

// File: tb/tb_aleste_vshift.sv
// tb/tb_aleste_vshift.sv - self-checking bench for aleste_vshift
module tb_aleste_vshift;
    import aleste_video_pkg::*;

    localparam int RST_MODE = 1;

    logic xtal = 1'b0;
    logic rst_n;
    logic high, hsync, disp_en, mvi_n, dis;
    logic [1:0] mode;
    logic [7:0] vdata;

    aleste_vshift_if vif();

    assign vif.high    = high;
    assign vif.mode    = mode;
    assign vif.hsync   = hsync;
    assign vif.disp_en = disp_en;
    assign vif.mvi_n   = mvi_n;
    assign vif.dis     = dis;
    assign vif.vdata   = vdata;

    aleste_vshift #(.RESET_MODE(2'(RST_MODE))) dut (
        .xtal  (xtal),
        .rst_n (rst_n),
        .vif   (vif)
    );

    always #5 xtal = ~xtal;

    int total = 0;
    int bad = 0;

    // Reference model: tracks edges since the last load and derives the
    // displayed pixel from elapsed time and the byte's captured parameters.
    int   edge_n = 0;
    int   ld_edge = 0;
    bit   m_loaded, m_unf, m_prev_mvi, m_prev_hs, m_vis;
    int   m_cur_mode, m_mode, m_len, m_hold, m_byte;
    logic [3:0] e_pen;
    logic e_border, e_stb, e_unf;

    function automatic int bit_of(int b, int p);
        return (b >> p) & 1;
    endfunction

    function automatic int ref_pen(int b, int m, int i);
        int m0;
        m0 = bit_of(b, 1 - (i % 2)) * 8 + bit_of(b, 5 - (i % 2)) * 4 +
             bit_of(b, 3 - (i % 2)) * 2 + bit_of(b, 7 - (i % 2));
        case (m)
            2: return bit_of(b, 7 - i);
            1: return bit_of(b, 3 - i) * 2 + bit_of(b, 7 - i);
            0: return m0;
            default: return m0 % 4;
        endcase
    endfunction

    task automatic model_reset();
        m_loaded   = 0;
        m_unf      = 0;
        m_prev_mvi = 1;
        m_prev_hs  = 1;
        m_cur_mode = RST_MODE;
        e_pen      = 4'd0;
        e_border   = 1'b1;
        e_stb      = 1'b0;
        e_unf      = 1'b0;
    endtask

    task automatic model_edge();
        int  k, i, ppb;
        bit  ld;
        edge_n++;
        k = edge_n - ld_edge;
        if (!m_loaded) begin
            e_pen = 4'd0; e_border = 1'b1; e_stb = 1'b0;
        end else if (k <= m_len) begin
            i        = (k - 1) / m_hold;
            e_pen    = m_vis ? 4'(ref_pen(m_byte, m_mode, i)) : 4'd0;
            e_border = !m_vis;
            e_stb    = ((k - 1) % m_hold) == 0;
        end else begin
            e_pen = 4'd0; e_border = 1'b1; e_stb = 1'b0;
            m_unf = 1;
        end
        e_unf = m_unf;
        if (hsync && !m_prev_hs) m_cur_mode = int'(mode);
        ld = !mvi_n && m_prev_mvi;
        if (ld) begin
            m_loaded = 1;
            ld_edge  = edge_n;
            m_byte   = int'(vdata);
            m_vis    = dis && disp_en;
            m_mode   = (high && m_cur_mode == 2) ? 1 : m_cur_mode;
            ppb      = (m_mode == 2) ? 8 : (m_mode == 1) ? 4 : 2;
            m_len    = high ? 4 : 8;
            m_hold   = m_len / ppb;
        end
        m_prev_mvi = mvi_n;
        m_prev_hs  = hsync;
    endtask

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge xtal);
        if (!rst_n) model_reset(); else model_edge();
        @(negedge xtal);
        chk("pen", vif.pen, e_pen);
        chk("border", 4'(vif.border), 4'(e_border));
        chk("pix_stb", 4'(vif.pix_stb), 4'(e_stb));
        chk("underrun", 4'(vif.underrun), 4'(e_unf));
    endtask

    logic [3:0] tab_a [8] = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] tab_b [8] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    logic [3:0] tab_c [4] = '{4'd3, 4'd2, 4'd2, 4'd2};

    initial begin
        rst_n = 1'b0; high = 1'b0; mode = 2'd0; hsync = 1'b0; disp_en = 1'b1;
        dis = 1'b1; mvi_n = 1'b1; vdata = 8'd0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Mode 1 from reset value (mode input is 0, no hsync yet): 8F.
        vdata = 8'h8F; mvi_n = 1'b0; tick();
        for (int k = 0; k < 8; k++) begin
            mvi_n = 1'b1; hsync = 1'b0; vdata = 8'($urandom);
            if (k == 7) begin mvi_n = 1'b0; vdata = 8'hAA; hsync = 1'b1; mode = 2'd0; end
            tick();
            chk("m1_pen", vif.pen, tab_a[k]);
            chk("m1_stb", 4'(vif.pix_stb), (k % 2 == 0) ? 4'd1 : 4'd0);
        end
        // Mode 0, AA (hsync edge coincided with the load).
        for (int k = 0; k < 8; k++) begin
            mvi_n = 1'b1; hsync = 1'b0; vdata = 8'($urandom);
            if (k == 7) begin mvi_n = 1'b0; vdata = 8'hAA; hsync = 1'b1; mode = 2'd3; end
            tick();
            chk("m0_pen", vif.pen, (k < 4) ? 4'd15 : 4'd0);
        end
        // Mode 3, AA.
        for (int k = 0; k < 8; k++) begin
            mvi_n = 1'b1; hsync = 1'b0; vdata = 8'($urandom);
            if (k == 7) begin mvi_n = 1'b0; vdata = 8'h81; hsync = 1'b1; mode = 2'd2; end
            tick();
            chk("m3_pen", vif.pen, (k < 4) ? 4'd3 : 4'd0);
        end
        // Mode 2, 81, one pixel per cycle.
        for (int k = 0; k < 8; k++) begin
            mvi_n = 1'b1; hsync = 1'b0; vdata = 8'($urandom);
            if (k == 7) begin mvi_n = 1'b0; vdata = 8'h8F; high = 1'b1; end
            tick();
            chk("m2_pen", vif.pen, tab_b[k]);
            chk("m2_stb", 4'(vif.pix_stb), 4'd1);
        end
        // high=1, mode 2 decodes as mode 1 over a 4-cycle byte.
        for (int k = 0; k < 4; k++) begin
            mvi_n = 1'b1; vdata = 8'($urandom);
            if (k == 3) begin mvi_n = 1'b0; high = 1'b0; dis = 1'b0; vdata = 8'hFF; end
            tick();
            chk("hi_pen", vif.pen, tab_c[k]);
        end
        // Non-display fetch: border whole byte, then underrun when starved.
        dis = 1'b1;
        for (int k = 0; k < 12; k++) begin
            mvi_n = 1'b1; vdata = 8'($urandom);
            tick();
            chk("nd_border", 4'(vif.border), 4'd1);
            chk("nd_pen", vif.pen, 4'd0);
            chk("nd_unf", 4'(vif.underrun), (k >= 8) ? 4'd1 : 4'd0);
        end

        // Reset during pixel 2 of a mode 1 byte clears underrun immediately.
        hsync = 1'b1; mode = 2'd1; mvi_n = 1'b0; vdata = 8'h8F; tick();
        hsync = 1'b0; mvi_n = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pen", vif.pen, 4'd0);
        chk("rst_border", 4'(vif.border), 4'd1);
        chk("rst_unf", 4'(vif.underrun), 4'd0);
        chk("rst_stb", 4'(vif.pix_stb), 4'd0);
        tick();
        rst_n = 1'b1; mode = 2'd0;
        tick();
        // First load after reset uses the reset mode (1), not the mode input.
        mvi_n = 1'b0; vdata = 8'h8F; tick();
        for (int k = 0; k < 8; k++) begin
            mvi_n = 1'b1; hsync = 1'b0; vdata = 8'($urandom);
            if (k == 7) begin mvi_n = 1'b0; vdata = 8'h3C; hsync = 1'b1; mode = 2'd0; end
            tick();
            chk("rm_pen", vif.pen, tab_a[k]);
        end
        // Mode 0 byte with a switch to mode 2 at a mid-byte hsync.
        for (int k = 0; k < 8; k++) begin
            mvi_n = 1'b1; hsync = 1'b0; vdata = 8'($urandom);
            if (k == 2) begin mode = 2'd2; hsync = 1'b1; end
            if (k == 7) begin mvi_n = 1'b0; vdata = 8'h81; end
            tick();
            chk("mid_pen", vif.pen, 4'd6);
        end
        // Strobe held low three cycles: one load, then underrun.
        for (int j = 0; j < 9; j++) begin
            mvi_n = (j < 2) ? 1'b0 : 1'b1; vdata = 8'($urandom);
            tick();
            if (j < 8) chk("one_pen", vif.pen, tab_b[j]);
            chk("one_unf", 4'(vif.underrun), (j == 8) ? 4'd1 : 4'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n   = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            mvi_n   = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
            hsync   = ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0;
            mode    = 2'($urandom);
            if ($urandom_range(0, 9) == 0) high = ~high;
            dis     = ($urandom_range(0, 5) != 0);
            disp_en = ($urandom_range(0, 5) != 0);
            vdata   = 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
